square_wave_freq_meter: RTL and testbench

//  Receive-side companion to the square-wave generator. It takes an 8-bit sample stream,
//  for example generator loopback or ADC capture, and turns it into a 1-bit level with

---
 rtl/square_wave_freq_meter_if.sv | 28 ++
 rtl/square_wave_freq_meter.sv | 153 +++++++++++++++
 tb/tb_square_wave_freq_meter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/square_wave_freq_meter_if.sv
`default_nettype none
// ============================================================================
// Module   : square_wave_freq_meter_if
// Brief    : Sample-in / measurement-out bundle for the square-wave meter.
// Revision : 1.0
// ============================================================================
interface square_wave_freq_meter_if #(
    parameter int PERIOD_W = 20
);
    logic [7:0]          wave_in;
    logic [PERIOD_W-1:0] period_out;
    logic [2:0]          freq_code;
    logic                meas_valid;
    logic                locked;
    logic                no_signal;
    logic                out_of_range;

    modport master (
        output wave_in,
        input  period_out, freq_code, meas_valid, locked, no_signal, out_of_range
    );

    modport slave (
        input  wave_in,
        output period_out, freq_code, meas_valid, locked, no_signal, out_of_range
    );
endinterface
`default_nettype wire

// File: rtl/square_wave_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : square_wave_freq_meter
// Brief    : Hysteresis slicer plus averaged rising-edge period meter that
//            classifies the result into the generator's freq_select code.
// Revision : 1.0
// ============================================================================
module square_wave_freq_meter #(
    parameter logic [7:0] HYST_HI     = 8'd192,
    parameter logic [7:0] HYST_LO     = 8'd64,
    parameter int         PERIOD_W    = 20,
    parameter int         AVG_LOG2    = 2,
    parameter int         TIMEOUT_CYC = 200000,
    parameter int         MIN_PERIOD  = 50,
    parameter int         MAX_PERIOD  = 3128
) (
    input  logic                    clk,
    input  logic                    reset,
    square_wave_freq_meter_if.slave bus
);
    localparam int                  c_ACC_W        = PERIOD_W + AVG_LOG2;
    localparam int                  c_NPER_W       = AVG_LOG2 + 1;
    localparam logic [c_NPER_W-1:0] c_NPER_LAST    = c_NPER_W'((1 << AVG_LOG2) - 1);
    localparam logic [PERIOD_W-1:0] c_CNT_MAX      = '1;
    localparam logic [PERIOD_W-1:0] c_TIMEOUT_LAST = PERIOD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_meas_valid;
    logic                r_lvl;
    logic                r_lvl_d;
    logic                w_rise;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_period;
    logic [c_ACC_W-1:0]  r_acc;
    logic [c_ACC_W-1:0]  w_acc_sum;
    logic [PERIOD_W-1:0] w_avg;
    logic [c_NPER_W-1:0] r_nper;
    logic                w_close;
    logic                w_timeout;
    logic [2:0]          w_code;
    logic                w_oor;
    logic [PERIOD_W-1:0] r_period_out;
    logic [2:0]          r_freq_code;
    logic                r_oor;
    logic                r_locked;
    logic                r_no_signal;
    logic                r_have_prev;

    assign w_rise    = r_lvl & ~r_lvl_d;
    assign w_period  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_acc_sum = r_acc + c_ACC_W'(w_period);
    assign w_avg     = PERIOD_W'(w_acc_sum >> AVG_LOG2);
    assign w_close   = (r_state == S_MEASURE) && w_rise && (r_nper == c_NPER_LAST);
    // A report cycle is always 1 cycle after a rise, so the counter cannot be near timeout there.
    assign w_timeout = (r_state != S_REPORT) && !w_rise && (r_cnt == c_TIMEOUT_LAST);

    // The report is classified from the closing sum so outputs are valid alongside meas_valid.
    always_comb begin
        w_code = 3'd7;
        if      (w_avg >= PERIOD_W'(1174)) w_code = 3'd0;
        else if (w_avg >= PERIOD_W'(654))  w_code = 3'd1;
        else if (w_avg >= PERIOD_W'(460))  w_code = 3'd2;
        else if (w_avg >= PERIOD_W'(330))  w_code = 3'd3;
        else if (w_avg >= PERIOD_W'(232))  w_code = 3'd4;
        else if (w_avg >= PERIOD_W'(166))  w_code = 3'd5;
        else if (w_avg >= PERIOD_W'(116))  w_code = 3'd6;
        w_oor = (w_avg < PERIOD_W'(MIN_PERIOD)) || (w_avg > PERIOD_W'(MAX_PERIOD));
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_meas_valid = 1'b0;
        case (r_state)
            S_IDLE:    if (w_rise) w_next_state = S_MEASURE;
            S_MEASURE: begin
                if (w_close)        w_next_state = S_REPORT;
                else if (w_timeout) w_next_state = S_IDLE;
            end
            S_REPORT: begin
                w_meas_valid = 1'b1;
                w_next_state = S_MEASURE;
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lvl        <= 1'b0;
            r_lvl_d      <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_nper       <= '0;
            r_period_out <= '0;
            r_freq_code  <= '0;
            r_oor        <= 1'b0;
            r_locked     <= 1'b0;
            r_no_signal  <= 1'b0;
            r_have_prev  <= 1'b0;
        end else begin
            if (bus.wave_in >= HYST_HI)      r_lvl <= 1'b1;
            else if (bus.wave_in <= HYST_LO) r_lvl <= 1'b0;
            r_lvl_d <= r_lvl;

            if (w_rise || w_timeout)   r_cnt <= '0;
            else if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 1'b1;

            if (w_rise) r_no_signal <= 1'b0;

            if (w_rise && r_state == S_IDLE) begin
                r_acc  <= '0;
                r_nper <= '0;
            end else if (w_close) begin
                r_acc        <= '0;
                r_nper       <= '0;
                r_period_out <= w_avg;
                r_freq_code  <= w_code;
                r_oor        <= w_oor;
                r_locked     <= r_have_prev && !r_oor && !w_oor && (w_code == r_freq_code);
                r_have_prev  <= 1'b1;
            end else if (w_rise && r_state == S_MEASURE) begin
                r_acc  <= w_acc_sum;
                r_nper <= r_nper + c_NPER_W'(1);
            end

            if (w_timeout) begin
                r_no_signal <= 1'b1;
                r_locked    <= 1'b0;
                r_have_prev <= 1'b0;
            end
        end
    end

    assign bus.period_out   = r_period_out;
    assign bus.freq_code    = r_freq_code;
    assign bus.meas_valid   = w_meas_valid;
    assign bus.locked       = r_locked;
    assign bus.no_signal    = r_no_signal;
    assign bus.out_of_range = r_oor;
endmodule
`default_nettype wire

// File: tb/tb_square_wave_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_wave_freq_meter
// Brief    : Randomised square-wave bench with an edge-time reference model.
// Revision : 1.0
// ============================================================================
module tb_square_wave_freq_meter;
    localparam int PERIOD_W = 20;
    localparam int TIMEOUT  = 6000;
    localparam int NAVG     = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [19:0] period;
        logic [2:0]  code;
        logic        oor;
        logic        locked;
    } rpt_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    square_wave_freq_meter_if #(.PERIOD_W(PERIOD_W)) bus ();
    square_wave_freq_meter #(.PERIOD_W(PERIOD_W), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    rpt_t exp_q[$];
    rpt_t obs_q[$];

    // Reference model: edge times from the hysteresis rule, periods by subtraction.
    bit       m_lvl, m_pend, m_idle, m_nsig, m_locked, m_have_prev, m_oor;
    logic [2:0] m_code;
    int       m_since, m_sum, m_n;

    function automatic logic [2:0] code_of(input int p);
        int bounds [7] = '{1174, 654, 460, 330, 232, 166, 116};
        for (int i = 0; i < 7; i++) if (p >= bounds[i]) return 3'(i);
        return 3'd7;
    endfunction

    always @(posedge clk) begin : model
        bit   rise_now;
        int   avg;
        rpt_t r;
        cyc = cyc + 1;
        if (!reset) begin
            m_lvl = 0; m_pend = 0; m_idle = 1; m_nsig = 0; m_locked = 0;
            m_have_prev = 0; m_oor = 0; m_code = 0; m_since = 0; m_sum = 0; m_n = 0;
        end else begin
            rise_now = m_pend;
            m_pend   = 0;
            if (bus.wave_in >= 8'd192) begin
                if (!m_lvl) m_pend = 1;
                m_lvl = 1;
            end else if (bus.wave_in <= 8'd64) m_lvl = 0;
            m_since++;
            if (rise_now) begin
                m_nsig = 0;
                if (m_idle) begin
                    m_idle = 0; m_sum = 0; m_n = 0;
                end else begin
                    m_sum += m_since;
                    m_n++;
                    if (m_n == NAVG) begin
                        avg      = m_sum / NAVG;
                        r.cyc    = cyc;
                        r.period = 20'(avg);
                        r.code   = code_of(avg);
                        r.oor    = (avg < 50) || (avg > 3128);
                        r.locked = m_have_prev && !m_oor && !r.oor && (r.code == m_code);
                        exp_q.push_back(r);
                        m_code = r.code; m_oor = r.oor; m_locked = r.locked;
                        m_have_prev = 1; m_sum = 0; m_n = 0;
                    end
                end
                m_since = 0;
            end else if (m_since == TIMEOUT) begin
                m_nsig = 1; m_locked = 0; m_have_prev = 0; m_idle = 1; m_since = 0;
            end
        end
    end

    always @(negedge clk) begin : observe
        rpt_t r;
        if (bus.meas_valid === 1'b1) begin
            r.cyc = cyc; r.period = bus.period_out; r.code = bus.freq_code;
            r.oor = bus.out_of_range; r.locked = bus.locked;
            obs_q.push_back(r);
        end
    end

    task automatic drive(input logic [7:0] v);
        @(posedge clk);
        #1 bus.wave_in = v;
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) drive(8'($urandom_range(64, 0)));
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Each period: low half then high half; noisy mode puts in-band samples at each transition.
    task automatic send_square(input int period, input int n, input bit noisy);
        bit         hi;
        int         ph;
        logic [7:0] v;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < period; i++) begin
                hi = (i >= period / 2);
                ph = hi ? i - period / 2 : i;
                if (noisy && ph < 6) v = 8'($urandom_range(168, 88));
                else if (hi)         v = 8'($urandom_range(255, 192));
                else                 v = 8'($urandom_range(64, 0));
                drive(v);
            end
        end
    endtask

    task automatic test_reset();
        bus.wave_in = 8'd0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.period_out !== '0 || bus.freq_code !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_value: period_out=%0d freq_code=%0d, expected 0/0", bus.period_out, bus.freq_code);
        end
        tests_run++;
        if ({bus.meas_valid, bus.locked, bus.no_signal, bus.out_of_range} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: valid/locked/nosig/oor=%b, expected 0000",
                     {bus.meas_valid, bus.locked, bus.no_signal, bus.out_of_range});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_nominal();
        rpt_t o, e;
        send_square(1564, 9, 0);
        hold_low(10);
        tests_run++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL nominal_count: got %0d reports, expected 2 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL nominal_report: got cyc=%0d p=%0d c=%0d oor=%b lk=%b, expected cyc=%0d p=%0d c=%0d oor=%b lk=%b",
                         o.cyc, o.period, o.code, o.oor, o.locked, e.cyc, e.period, e.code, e.oor, e.locked);
            end
        end
        tests_run++;
        if (o.period !== 20'd1564 || o.code !== 3'd0 || o.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL nominal_final: got p=%0d c=%0d lk=%b, expected p=1564 c=0 lk=1", o.period, o.code, o.locked);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_switch();
        rpt_t o, e;
        rpt_t seen[$];
        pulse_reset(1);
        send_square(100, 9, 0);
        send_square(396, 9, 0);
        hold_low(10);
        tests_run++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL switch_count: got %0d reports, expected 4 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            seen.push_back(o);
            if (o !== e) begin
                tests_failed++;
                $display("FAIL switch_report: got cyc=%0d p=%0d c=%0d oor=%b lk=%b, expected cyc=%0d p=%0d c=%0d oor=%b lk=%b",
                         o.cyc, o.period, o.code, o.oor, o.locked, e.cyc, e.period, e.code, e.oor, e.locked);
            end
        end
        if (seen.size() == 4) begin
            tests_run++;
            if (seen[1].period !== 20'd100 || seen[1].code !== 3'd7) begin
                tests_failed++;
                $display("FAIL switch_100: got p=%0d c=%0d, expected p=100 c=7", seen[1].period, seen[1].code);
            end
            tests_run++;
            if (seen[2].code !== 3'd3 || seen[2].locked !== 1'b0 || seen[3].locked !== 1'b1) begin
                tests_failed++;
                $display("FAIL switch_396_lock: got c=%0d lk=%b then lk=%b, expected c=3 lk=0 then lk=1",
                         seen[2].code, seen[2].locked, seen[3].locked);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_noise();
        rpt_t o, e;
        pulse_reset(1);
        send_square(264, 9, 1);
        hold_low(10);
        tests_run++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL noise_count: got %0d reports, expected 2 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL noise_report: got cyc=%0d p=%0d c=%0d oor=%b lk=%b, expected cyc=%0d p=%0d c=%0d oor=%b lk=%b",
                         o.cyc, o.period, o.code, o.oor, o.locked, e.cyc, e.period, e.code, e.oor, e.locked);
            end
        end
        tests_run++;
        if (o.period !== 20'd264 || o.code !== 3'd4) begin
            tests_failed++;
            $display("FAIL noise_final: got p=%0d c=%0d, expected p=264 c=4", o.period, o.code);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_range();
        rpt_t o, e;
        rpt_t seen[$];
        pulse_reset(1);
        send_square(40, 9, 0);
        hold_low(10);
        pulse_reset(1);
        send_square(4000, 5, 0);
        hold_low(10);
        tests_run++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() !== 3) begin
            tests_failed++;
            $display("FAIL range_count: got %0d reports, expected 3 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            seen.push_back(o);
            if (o !== e) begin
                tests_failed++;
                $display("FAIL range_report: got cyc=%0d p=%0d c=%0d oor=%b lk=%b, expected cyc=%0d p=%0d c=%0d oor=%b lk=%b",
                         o.cyc, o.period, o.code, o.oor, o.locked, e.cyc, e.period, e.code, e.oor, e.locked);
            end
        end
        if (seen.size() == 3) begin
            tests_run++;
            if (seen[1].oor !== 1'b1 || seen[1].locked !== 1'b0 || seen[1].code !== 3'd7) begin
                tests_failed++;
                $display("FAIL range_fast: got oor=%b lk=%b c=%0d, expected oor=1 lk=0 c=7", seen[1].oor, seen[1].locked, seen[1].code);
            end
            tests_run++;
            if (seen[2].oor !== 1'b1 || seen[2].code !== 3'd0 || seen[2].period !== 20'd4000) begin
                tests_failed++;
                $display("FAIL range_slow: got oor=%b c=%0d p=%0d, expected oor=1 c=0 p=4000", seen[2].oor, seen[2].code, seen[2].period);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_timeout();
        int mism;
        int k;
        mism = 0;
        k    = 0;
        while (!m_nsig && k < TIMEOUT + 1000) begin
            drive(8'($urandom_range(64, 0)));
            @(negedge clk);
            if (bus.no_signal !== m_nsig) mism++;
            k++;
        end
        tests_run++;
        if (!m_nsig) begin
            tests_failed++;
            $display("FAIL timeout_bound: no timeout after %0d cycles, expected within %0d", k, TIMEOUT);
        end
        tests_run++;
        if (mism != 0) begin
            tests_failed++;
            $display("FAIL timeout_timing: no_signal differed from model on %0d cycles, expected 0", mism);
        end
        tests_run++;
        if (bus.no_signal !== 1'b1 || bus.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_flags: got nosig=%b lk=%b, expected nosig=1 lk=0", bus.no_signal, bus.locked);
        end
        tests_run++;
        if (bus.period_out !== 20'd4000 || bus.freq_code !== 3'd0) begin
            tests_failed++;
            $display("FAIL timeout_hold: got p=%0d c=%0d, expected p=4000 c=0", bus.period_out, bus.freq_code);
        end
        send_square(264, 1, 0);
        hold_low(3);
        @(negedge clk);
        tests_run++;
        if (bus.no_signal !== 1'b0 || bus.meas_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear: got nosig=%b valid=%b, expected 0/0", bus.no_signal, bus.meas_valid);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        rpt_t o, e;
        pulse_reset(1);
        send_square(264, 6, 0);
        hold_low(100);
        exp_q.delete(); obs_q.delete();
        pulse_reset(1);
        @(negedge clk);
        tests_run++;
        if ({bus.period_out, bus.freq_code, bus.meas_valid, bus.locked, bus.no_signal, bus.out_of_range} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got p=%0d c=%0d v/l/n/o=%b, expected all 0", bus.period_out, bus.freq_code,
                     {bus.meas_valid, bus.locked, bus.no_signal, bus.out_of_range});
        end
        send_square(264, 4, 0);
        hold_low(10);
        tests_run++;
        if (obs_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL midreset_early: got %0d reports after 3 periods, expected 0", obs_q.size());
        end
        send_square(264, 1, 0);
        hold_low(10);
        tests_run++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d reports, expected 1 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e || o.locked !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_report: got cyc=%0d p=%0d c=%0d oor=%b lk=%b, expected cyc=%0d p=%0d c=%0d oor=%b lk=%b",
                         o.cyc, o.period, o.code, o.oor, o.locked, e.cyc, e.period, e.code, e.oor, e.locked);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        bus.wave_in = 8'd0;
        reset       = 1'b0;
        test_reset();
        test_nominal();
        test_switch();
        test_noise();
        test_range();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
